// File: rtl/rr_sel_pkg.sv
// Shared types and constants for the round-robin select arbiter that drives
// the 4:1 mux select.
package rr_sel_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } rr_state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_sel_pick.sv
// Combinational round-robin picker: rotates req so that ptr sits at bit 0,
// finds the lowest set bit, then rotates the result back into an index.
module rr_sel_pick
    import rr_sel_pkg::*;
(
    input  logic [3:0] req,
    input  sel_t       ptr,
    output logic       any,
    output sel_t       win
);

    logic [3:0] rot;
    sel_t       off;

    always_comb begin
        rot = 4'b0000;
        off = '0;
        for (int i = 0; i < 4; i++) begin
            rot[i] = req[ptr + sel_t'(i)];
        end
        // Descending scan, so the lowest set bit (closest to ptr) wins.
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) begin
                off = sel_t'(i);
            end
        end
        any = |req;
        win = ptr + off;
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter for four requesters feeding a 4:1 mux select.
// Optional feature: define RR_SEL_HOLD_LIMIT_EN to cap an owner's tenure at HOLD_MAX cycles.
module rr_sel_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    import rr_sel_pkg::*;

    generate
        if (NREQ != 4) begin : g_bad_nreq
            $error("rr_sel_arbiter: NREQ must be 4");
        end
        if (CNT_W < $clog2(HOLD_MAX + 1)) begin : g_bad_cnt_w
            $error("rr_sel_arbiter: CNT_W too narrow for HOLD_MAX");
        end
    endgenerate

    rr_state_t state, state_n;
    sel_t      ptr, ptr_n;
    sel_t      sel_n;
    logic      any;
    sel_t      win;
    logic      force_rot;

    rr_sel_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .win (win)
    );

`ifdef RR_SEL_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             others;

    always_comb begin
        others    = |(req & ~(4'b0001 << sel));
        force_rot = (hold_cnt == CNT_W'(HOLD_MAX)) && others;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_n;
        end
    end
`else
    assign force_rot = 1'b0;
`endif

    // ptr always sits one past the current owner, so a forced rotation can
    // never pick the owner again while anyone else is waiting.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
`ifdef RR_SEL_HOLD_LIMIT_EN
        hold_n  = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (any) begin
                    state_n = GRANT;
                    sel_n   = win;
                    ptr_n   = win + sel_t'(1);
`ifdef RR_SEL_HOLD_LIMIT_EN
                    hold_n  = CNT_W'(1);
`endif
                end
            end
            GRANT: begin
                if (req[sel] && !force_rot) begin
`ifdef RR_SEL_HOLD_LIMIT_EN
                    if (hold_cnt != CNT_W'(HOLD_MAX)) begin
                        hold_n = hold_cnt + CNT_W'(1);
                    end
`endif
                end else if (any) begin
                    sel_n   = win;
                    ptr_n   = win + sel_t'(1);
`ifdef RR_SEL_HOLD_LIMIT_EN
                    hold_n  = CNT_W'(1);
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
        end
    end

    // gnt is decoded from registers only, so it stays glitch-free and one-hot.
    always_comb begin
        busy = (state == GRANT);
        gnt  = busy ? (4'b0001 << sel) : 4'b0000;
    end

endmodule
